// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared types and register map for the APB timer scheduler.
// Holds the FSM state enum, the write-sequence step enum, the timer register
// word addresses and control values, plus a helper that maps a step to the
// APB address/data pair it issues.
package apb_timer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        WAIT_INT = 3'd3,
        FIN      = 3'd4
    } state_e;

    // Position within the four-write programming sequence.
    typedef enum logic [1:0] {
        STEP_RELOAD = 2'd0,
        STEP_RUN    = 2'd1,
        STEP_INTCLR = 2'd2,
        STEP_STOP   = 2'd3
    } step_e;

    localparam logic [9:0]  ADDR_CTRL    = 10'h000;
    localparam logic [9:0]  ADDR_RELOAD  = 10'h002;
    localparam logic [9:0]  ADDR_INTCLR  = 10'h003;

    localparam logic [31:0] CTRL_RUN_IRQ = 32'h9;
    localparam logic [31:0] CTRL_STOP    = 32'h0;
    localparam logic [31:0] INTCLR_ACK   = 32'h1;

    // {PADDR, PWDATA} for a given step; only RELOAD carries the requester load.
    function automatic logic [41:0] step_write(input step_e step, input logic [31:0] load);
        case (step)
            STEP_RELOAD: return {ADDR_RELOAD, load};
            STEP_RUN:    return {ADDR_CTRL, CTRL_RUN_IRQ};
            STEP_INTCLR: return {ADDR_INTCLR, INTCLR_ACK};
            default:     return {ADDR_CTRL, CTRL_STOP};
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with one-hot grant.
// The search starts one past the last index granted; the pointer only moves
// when advance_i is high and some request is present. After reset the pointer
// sits at NREQ-1 so requester 0 wins first.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic                     advance_i,
    output logic [NREQ-1:0]          grant_o,
    output logic                     valid_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] win_idx;

    // Find the first active request after the last winner, wrapping around.
    always_comb begin
        int            cand;
        logic [IW-1:0] sel;
        cand    = 0;
        sel     = '0;
        grant_o = '0;
        valid_o = 1'b0;
        win_idx = last_q;
        for (int off = 1; off <= NREQ; off++) begin
            cand = int'(last_q) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            sel = IW'(cand);
            if (!valid_o && req_i[sel]) begin
                valid_o      = 1'b1;
                grant_o[sel] = 1'b1;
                win_idx      = sel;
            end
        end
        last_d = (advance_i && valid_o) ? win_idx : last_q;
    end

    // Pointer register; reset value makes index 0 the first candidate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_timer_sched.sv
// apb_timer_sched: shares one APB timer among NREQ requesters.
// A granted requester gets: RELOAD=load, CTRL=run+irq, wait for TIMERINT,
// INTCLR=1, CTRL=0, then a one-cycle done pulse. A zero load, a slave error
// or (optionally) an interrupt timeout produces an err pulse instead; the
// error/timeout abort path writes CTRL=0 once before reporting.
// Optional feature macro: APB_TIMER_SCHED_TMO_EN enables the WAIT_INT timeout
// counter (aborts after 2^TMO_W-1 cycles without TIMERINT).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no grant; arbitrates among req
// SETUP    | APB setup phase of current step (or zero-load err cycle)
// ACCESS   | APB access phase, held until PREADY
// WAIT_INT | timer running, waiting for TIMERINT (PSEL low)
// FIN      | one-cycle done (or err after abort) pulse
module apb_timer_sched
    import apb_timer_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TMO_W = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_load,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [11:2]          PADDR,
    output logic [31:0]          PWDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    input  logic                 TIMERINT
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("apb_timer_sched: NREQ must be within 2..8");
    end
    if (TMO_W < 2 || TMO_W > 32) begin : g_bad_tmo_w
        $error("apb_timer_sched: TMO_W must be within 2..32");
    end

    state_e          state_q, state_d;
    step_e           step_q, step_d;
    logic            abort_q, abort_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [31:0]     load_q, load_d;

    logic [NREQ-1:0] arb_grant;
    logic            arb_valid;
    logic [31:0]     sel_load;
    logic            zero_setup;
    logic            apb_on;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .req_i     (req),
        .advance_i (state_q == IDLE),
        .grant_o   (arb_grant),
        .valid_o   (arb_valid)
    );

    // Pick the winning requester's reload word.
    always_comb begin
        sel_load = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_load = req_load[32*i +: 32];
            end
        end
    end

    // A zero load is rejected in the first SETUP cycle without driving PSEL.
    assign zero_setup = (state_q == SETUP) && (step_q == STEP_RELOAD) && (load_q == '0);
    assign apb_on     = ((state_q == SETUP) && !zero_setup) || (state_q == ACCESS);

`ifdef APB_TIMER_SCHED_TMO_EN
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;

    // Hit on the cycle the running count reaches all-ones.
    assign tmo_hit = (tmo_q == ({TMO_W{1'b1}} - TMO_W'(1)));

    // Count WAIT_INT cycles; cleared in every other state.
    always_ff @(posedge PCLK) begin
        if (PRESET || (state_q != WAIT_INT)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched grant context: step, abort flag, grant vector and load.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            step_q  <= STEP_RELOAD;
            abort_q <= 1'b0;
            gnt_q   <= '0;
            load_q  <= '0;
        end else begin
            step_q  <= step_d;
            abort_q <= abort_d;
            gnt_q   <= gnt_d;
            load_q  <= load_d;
        end
    end

    // Next-state and sequence-step logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        abort_d = abort_q;
        gnt_d   = gnt_q;
        load_d  = load_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = SETUP;
                    gnt_d   = arb_grant;
                    load_d  = sel_load;
                    step_d  = STEP_RELOAD;
                    abort_d = 1'b0;
                end
            end
            SETUP: begin
                state_d = zero_setup ? IDLE : ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR && !abort_q) begin
                        // Stop the timer once; errors on that write are ignored.
                        abort_d = 1'b1;
                        step_d  = STEP_STOP;
                        state_d = SETUP;
                    end else begin
                        case (step_q)
                            STEP_RELOAD: begin
                                step_d  = STEP_RUN;
                                state_d = SETUP;
                            end
                            STEP_RUN: begin
                                step_d  = STEP_INTCLR;
                                state_d = WAIT_INT;
                            end
                            STEP_INTCLR: begin
                                step_d  = STEP_STOP;
                                state_d = SETUP;
                            end
                            default: begin
                                state_d = FIN;
                            end
                        endcase
                    end
                end
            end
            WAIT_INT: begin
                if (TIMERINT) begin
                    state_d = SETUP;
                end
`ifdef APB_TIMER_SCHED_TMO_EN
                else if (tmo_hit) begin
                    abort_d = 1'b1;
                    step_d  = STEP_STOP;
                    state_d = SETUP;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs: APB drive, busy and the done/err pulses.
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        if (apb_on) begin
            PSEL            = 1'b1;
            PENABLE         = (state_q == ACCESS);
            PWRITE          = 1'b1;
            {PADDR, PWDATA} = step_write(step_q, load_q);
        end
        busy = (state_q != IDLE);
        done = ((state_q == FIN) && !abort_q) ? gnt_q : '0;
        err  = (((state_q == FIN) && abort_q) || zero_setup) ? gnt_q : '0;
    end

endmodule

// File: tb/tb_apb_timer_sched.sv
// tb_apb_timer_sched: directed scoreboard bench for apb_timer_sched.
// Expected APB writes and done/err events are queued as stimulus is issued
// and popped by a negedge monitor. A small APB/timer responder supplies
// PREADY stalls, PSLVERR and a delayed TIMERINT. The interrupt-timeout part
// follows APB_TIMER_SCHED_TMO_EN.
module tb_apb_timer_sched;

    localparam int NREQ  = 2;
    localparam int TMO_W = 4;

    logic                PCLK = 1'b0;
    logic                PRESET;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  req_load;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic                busy;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [11:2]         PADDR;
    logic [31:0]         PWDATA;
    logic                PREADY;
    logic                PSLVERR;
    logic                TIMERINT;

    apb_timer_sched #(
        .NREQ  (NREQ),
        .TMO_W (TMO_W)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req      (req),
        .req_load (req_load),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .TIMERINT (TIMERINT)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          nacc;
    } wr_t;

    typedef struct {
        logic [NREQ-1:0] done;
        logic [NREQ-1:0] err;
    } ev_t;

    wr_t exp_wr[$];
    ev_t exp_ev[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- responder ----------------
    logic stall_en  = 1'b0;
    logic slv_en    = 1'b0;
    logic int_en    = 1'b1;
    int   int_delay = 5;
    int   int_cnt   = 0;
    int   acc_cnt   = 0;

    assign PREADY  = !(stall_en && PENABLE && (PADDR == 10'h002) && (acc_cnt < 3));
    assign PSLVERR = slv_en && PENABLE && (PADDR == 10'h000);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    always @(posedge PCLK) begin
        if (PRESET) begin
            TIMERINT <= 1'b0;
            int_cnt  <= 0;
        end else begin
            if (int_cnt == 1) TIMERINT <= 1'b1;
            if (int_cnt > 0)  int_cnt  <= int_cnt - 1;
            if (int_en && PSEL && PENABLE && PREADY && !PSLVERR &&
                (PADDR == 10'h000) && (PWDATA == 32'h9))
                int_cnt <= int_delay;
            if (PSEL && PENABLE && PREADY && (PADDR == 10'h003))
                TIMERINT <= 1'b0;
        end
    end

    // ---------------- monitor ----------------
    int          cur_acc  = 0;
    int          wr_seen  = 0;
    int          psel_cnt = 0;
    logic [9:0]  su_addr  = '0;
    logic [31:0] su_data  = '0;

    always @(negedge PCLK) begin
        wr_t w;
        ev_t e;
        if (PRESET) begin
            cur_acc = 0;
        end else begin
            if (PSEL) psel_cnt++;
            if (PSEL && !PENABLE) begin
                su_addr = PADDR;
                su_data = PWDATA;
                cur_acc = 0;
            end
            if (PSEL && PENABLE) begin
                cur_acc++;
                chk("access_stable", {PADDR, PWDATA}, {su_addr, su_data});
            end
            if (PSEL && PENABLE && PREADY) begin
                chk("pwrite", PWRITE, 1);
                chk("wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", PADDR, w.addr);
                    chk("wr_data", PWDATA, w.data);
                    chk("wr_naccess", cur_acc, w.nacc);
                end
                wr_seen++;
            end
            if ((done | err) != '0) begin
                chk("done_err_onehot", $countones(done | err), 1);
                chk("ev_expected", exp_ev.size() > 0, 1);
                if (exp_ev.size() > 0) begin
                    e = exp_ev.pop_front();
                    chk("ev_done", done, e.done);
                    chk("ev_err", err, e.err);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_wr(input logic [9:0] a, input logic [31:0] d, input int n);
        wr_t w;
        w.addr = a; w.data = d; w.nacc = n;
        exp_wr.push_back(w);
    endtask

    task automatic push_ev(input logic [NREQ-1:0] d, input logic [NREQ-1:0] e);
        ev_t v;
        v.done = d; v.err = e;
        exp_ev.push_back(v);
    endtask

    task automatic push_full_seq(input logic [31:0] load, input logic [NREQ-1:0] who);
        push_wr(10'h002, load, 1);
        push_wr(10'h000, 32'h9, 1);
        push_wr(10'h003, 32'h1, 1);
        push_wr(10'h000, 32'h0, 1);
        push_ev(who, '0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        tick(2);
        PRESET = 1'b0;
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        req = r;
        tick(1);
        req = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        do begin
            @(negedge PCLK);
            k++;
        end while (busy && k < budget);
        chk(tag, busy, 0);
    endtask

    task automatic wait_ctrl_run(input string tag);
        int   k = 0;
        logic found = 1'b0;
        while (!found && k < 60) begin
            @(negedge PCLK);
            k++;
            if (PSEL && PENABLE && PREADY && PADDR == 10'h000 && PWDATA == 32'h9) found = 1'b1;
        end
        chk(tag, found, 1);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
        chk({tag, "_ev_left"}, exp_ev.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        int p0;
        PRESET   = 1'b1;
        req      = '0;
        req_load = '0;

        // Reset state
        @(posedge PCLK);
        @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        tick(1);

        // Basic sequence; req and load change after grant and must be ignored
        req_load = {32'd0, 32'd10};
        push_full_seq(32'd10, 2'b01);
        req = 2'b01;
        tick(1);
        req = '0;
        req_load[31:0] = 32'd77;
        @(negedge PCLK);
        chk("lat_setup", {PSEL, PENABLE}, 2'b10);
        chk("lat_paddr", PADDR, 10'h002);
        @(negedge PCLK);
        chk("first_access", {PSEL, PENABLE}, 2'b11);
        @(negedge PCLK);
        chk("b2b_setup", {PSEL, PENABLE}, 2'b10);
        wait_idle("seqA_idle", 200);
        chk_drained("seqA");

        // Round robin 0,1,0 from reset with both requesting
        do_reset();
        req_load = {32'h30, 32'h20};
        push_full_seq(32'h20, 2'b01);
        push_full_seq(32'h30, 2'b10);
        push_full_seq(32'h20, 2'b01);
        base = wr_seen;
        req  = 2'b11;
        for (int k = 0; k < 400 && wr_seen < base + 9; k++) tick(1);
        chk("rr_third_grant", wr_seen >= base + 9, 1);
        req = '0;
        wait_idle("rr_idle", 200);
        chk_drained("rr");

        // PREADY stalls three ACCESS cycles on RELOAD
        stall_en = 1'b1;
        req_load = {32'd0, 32'h55};
        push_wr(10'h002, 32'h55, 4);
        push_wr(10'h000, 32'h9, 1);
        push_wr(10'h003, 32'h1, 1);
        push_wr(10'h000, 32'h0, 1);
        push_ev(2'b01, '0);
        pulse_req(2'b01);
        wait_idle("stall_idle", 200);
        stall_en = 1'b0;
        chk_drained("stall");

        // PSLVERR on CTRL writes: abort write ignores its own error
        slv_en   = 1'b1;
        req_load = {32'd0, 32'h40};
        push_wr(10'h002, 32'h40, 1);
        push_wr(10'h000, 32'h9, 1);
        push_wr(10'h000, 32'h0, 1);
        push_ev('0, 2'b01);
        pulse_req(2'b01);
        wait_idle("slverr_idle", 200);
        tick(3);
        chk("slverr_busy_after", busy, 0);
        slv_en = 1'b0;
        chk_drained("slverr");

        // Zero load: err one cycle after grant, no APB traffic
        req_load = '0;
        push_ev('0, 2'b01);
        p0 = psel_cnt;
        req = 2'b01;
        tick(1);
        req = '0;
        @(negedge PCLK);
        chk("zero_err_timing", err, 2'b01);
        chk("zero_psel", PSEL, 0);
        tick(4);
        chk("zero_no_psel", psel_cnt, p0);
        chk("zero_busy", busy, 0);
        chk_drained("zero");

        // Reset while waiting for the interrupt
        int_en   = 1'b0;
        req_load = {32'd0, 32'h66};
        push_wr(10'h002, 32'h66, 1);
        push_wr(10'h000, 32'h9, 1);
        pulse_req(2'b01);
        wait_ctrl_run("midrst_ctrl_seen");
        tick(3);
        chk("midrst_wait_psel", PSEL, 0);
        chk("midrst_wait_busy", busy, 1);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        chk("midrst_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, err, busy}, 0);
        PRESET = 1'b0;
        tick(1);
        chk_drained("midrst");

`ifdef APB_TIMER_SCHED_TMO_EN
        // Interrupt never arrives: abort after 2^TMO_W-1 WAIT_INT cycles
        req_load = {32'd0, 32'h77};
        push_wr(10'h002, 32'h77, 1);
        push_wr(10'h000, 32'h9, 1);
        push_wr(10'h000, 32'h0, 1);
        push_ev('0, 2'b01);
        pulse_req(2'b01);
        wait_ctrl_run("tmo_ctrl_seen");
        n = 0;
        do begin
            @(negedge PCLK);
            if (!PSEL) n++;
        end while (!PSEL && n < 60);
        chk("tmo_wait_cycles", n, 15);
        wait_idle("tmo_idle", 100);
        chk_drained("tmo");
`else
        // Interrupt never arrives: the block keeps waiting
        req_load = {32'd0, 32'h77};
        push_wr(10'h002, 32'h77, 1);
        push_wr(10'h000, 32'h9, 1);
        pulse_req(2'b01);
        wait_ctrl_run("noint_ctrl_seen");
        tick(300);
        chk("noint_busy", busy, 1);
        chk("noint_psel", PSEL, 0);
        chk_drained("noint");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_timer_sched.md
APB_TIMER_SCHED -- requirements
Module: apb_timer_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing the timer (2..8).
REQ-002 SHALL have parameter TMO_W, default 16, width of the interrupt-wait timeout counter.
REQ-003 SHALL have port PCLK, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port PRESET, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port req, input, NREQ, level request per requester.
REQ-006 SHALL have port req_load, input, 32*NREQ; requester i's reload value is in bits [32i+31:32i].
REQ-007 SHALL have port done, output, NREQ, one-cycle pulse when requester i's timer period has completed.
REQ-008 SHALL have port err, output, NREQ, one-cycle pulse when requester i's sequence was aborted.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have APB master ports PSEL, PENABLE, PWRITE (outputs, 1 bit each), PADDR (output, [11:2]) and PWDATA (output, 32).
REQ-011 SHALL have APB slave-response ports PREADY and PSLVERR (inputs, 1 bit each).
REQ-012 SHALL have port TIMERINT, input, 1, the level interrupt from the timer.

Function
REQ-013 SHALL implement states IDLE, SETUP, ACCESS, WAIT_INT, FIN.
REQ-014 In IDLE with any req high, SHALL grant one requester by round-robin.
  - Priority starts after the last granted index.
  - The granted index and its req_load SHALL be latched, and the next state is SETUP.
REQ-015 If the latched load is 0, SHALL pulse err[grant] the next cycle, return to IDLE and issue no APB traffic.
REQ-016 SHALL issue these APB writes in order, all with PWRITE=1:
  - PADDR 10'h002 with the load.
  - PADDR 10'h000 with 32'h9.
  - Wait for TIMERINT.
  - PADDR 10'h003 with 32'h1.
  - PADDR 10'h000 with 32'h0.
REQ-017 Each write SHALL consist of one SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1).
  - ACCESS SHALL be held until PREADY=1.
  - PADDR and PWDATA SHALL be stable across SETUP and ACCESS.
REQ-018 Back-to-back writes SHALL go ACCESS directly to the next SETUP; PSEL SHALL stay high and PENABLE SHALL drop.
REQ-019 PSLVERR=1 in a completing ACCESS cycle SHALL abort the sequence.
  - An abort writes CTRL=0 once, ignoring any PSLVERR on that write.
  - err[grant] SHALL then pulse and the block returns to IDLE.
REQ-020 In WAIT_INT, PSEL SHALL be 0; the block SHALL move to the INTCLEAR write on the first cycle TIMERINT=1.
REQ-021 FIN SHALL pulse done[grant] for exactly one cycle, then enter IDLE; the next grant can occur the following cycle.
REQ-022 Deasserting req or changing req_load while granted SHALL be ignored; the latched values are used.
REQ-023 With PREADY tied 1, the latency from IDLE sampling req to the first SETUP SHALL be 1 cycle, and each write SHALL take 2 cycles.
REQ-024 At most one bit of done|err SHALL be high in any cycle.

Reset
REQ-025 On PRESET=1 at a rising edge, the block SHALL force:
  - state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
  - done=0, err=0, busy=0;
  - round-robin pointer set so requester 0 wins first;
  - timeout counter cleared.
REQ-026 Reset mid-transfer SHALL drop PSEL and PENABLE at that same edge, with no completing cycle.

Configuration
REQ-027 With APB_TIMER_SCHED_TMO_EN defined, WAIT_INT SHALL count cycles.
  - When the count reaches 2^TMO_W-1 without TIMERINT, the block SHALL take the abort path of REQ-019.
  - Without the macro, WAIT_INT SHALL wait indefinitely and no counter SHALL exist.

Structure
REQ-028 Package apb_timer_pkg SHALL hold:
  - the state enum;
  - register word addresses ADDR_CTRL=10'h000, ADDR_RELOAD=10'h002, ADDR_INTCLR=10'h003;
  - CTRL_RUN_IRQ=32'h9.
REQ-029 The round-robin arbiter SHALL be a sub-module, rr_arbiter (NREQ-wide req, one-hot grant, advance strobe).

Verification
REQ-030 req=01, load0=10, PREADY=1, TIMERINT raised 5 cycles after CTRL write -> writes (002,10),(000,9),(003,1),(000,0); done=01 pulse once.
REQ-031 req=11 held for three sequences -> grants 0,1,0; each done pulses on the matching bit only.
REQ-032 PREADY low for 3 ACCESS cycles on the RELOAD write -> PADDR/PWDATA stable, 4 ACCESS cycles, sequence then continues.
REQ-033 PSLVERR=1 on the CTRL write -> one write (000,0), err pulse, no INTCLEAR write, busy=0 afterwards.
REQ-034 load0=0 -> err[0] pulse 1 cycle after grant, PSEL never asserted.
REQ-035 Macro defined, TMO_W=4, TIMERINT never raised -> abort after 15 WAIT_INT cycles; err pulses. Macro undefined -> busy stays 1 indefinitely. PRESET mid-WAIT_INT -> all outputs 0 next cycle.
